// File: rtl/f_int_normalize.sv
// rtl/f_int_normalize.sv - integer-to-float front end: sign/magnitude split and iterative normalize
// Emits sign, left-justified significand and biased exponent for the FPU rounding stage.
module f_int_normalize (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] int_i,
    input  logic        signed_i,
    input  logic [2:0]  rm_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        sign_o,
    output logic [31:0] sig_o,
    output logic [7:0]  exp_o,
    output logic        zero_o,
    output logic [2:0]  rm_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sig_q, sig_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        zero_q, zero_d;
    logic        valid_q, valid_d;
    logic [2:0]  rm_q, rm_d;

    logic        in_sign;
    logic [31:0] in_mag;

    // -2^31 negates to itself, which is exactly the magnitude we want when read unsigned
    assign in_sign = signed_i & int_i[31];
    assign in_mag  = in_sign ? (~int_i + 32'd1) : int_i;

    assign ready_o = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        valid_d = valid_q;
        rm_d    = rm_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    sig_d  = in_mag;
                    sign_d = in_sign;
                    rm_d   = rm_i;
                    cnt_d  = 5'd0;
                    if (in_mag == 32'd0) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        zero_d  = 1'b1;
                        exp_d   = 8'd0;
                        sign_d  = 1'b0;
                    end else begin
                        state_d = NORM;
                        zero_d  = 1'b0;
                    end
                end
            end
            NORM: begin
                if (sig_q[31]) begin
                    exp_d   = 8'd158 - {3'b000, cnt_q};
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (sig_q[31:24] == 8'd0) begin
                    sig_d = {sig_q[23:0], 8'd0};
                    cnt_d = cnt_q + 5'd8;
                end else begin
                    sig_d = {sig_q[30:0], 1'b0};
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sig_q   <= 32'd0;
            cnt_q   <= 5'd0;
            exp_q   <= 8'd0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            rm_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
            rm_q    <= rm_d;
        end
    end

    assign valid_o = valid_q;
    assign sign_o  = sign_q;
    assign sig_o   = sig_q;
    assign exp_o   = exp_q;
    assign zero_o  = zero_q;
    assign rm_o    = rm_q;

endmodule

// File: tb/tb_f_int_normalize.sv
// tb/tb_f_int_normalize.sv - scoreboard bench for f_int_normalize with directed vectors
module tb_f_int_normalize;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] int_i;
    logic        signed_i;
    logic [2:0]  rm_i;
    logic        valid_o;
    logic        ready_i;
    logic        sign_o;
    logic [31:0] sig_o;
    logic [7:0]  exp_o;
    logic        zero_o;
    logic [2:0]  rm_o;

    typedef struct packed {
        logic        sign;
        logic [31:0] sig;
        logic [7:0]  expo;
        logic        zero;
        logic [2:0]  rm;
    } res_t;

    res_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    f_int_normalize dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .int_i   (int_i),
        .signed_i(signed_i),
        .rm_i    (rm_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sign_o  (sign_o),
        .sig_o   (sig_o),
        .exp_o   (exp_o),
        .zero_o  (zero_o),
        .rm_o    (rm_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    // Monitor: a result is consumed on the edge following a negedge with valid_o && ready_i
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_result: got sig %08h with empty scoreboard", sig_o);
            end else begin
                res_t e;
                res_t a;
                e = exp_q.pop_front();
                a = '{sign: sign_o, sig: sig_o, expo: exp_o, zero: zero_o, rm: rm_o};
                if (a === e) n_pass++;
                else $display("FAIL result: got s=%0b sig=%08h e=%0d z=%0b rm=%0d want s=%0b sig=%08h e=%0d z=%0b rm=%0d",
                              a.sign, a.sig, a.expo, a.zero, a.rm, e.sign, e.sig, e.expo, e.zero, e.rm);
            end
        end
    end

    // Called at posedge+1 with ready_o high; returns at posedge+1 once valid_o is seen
    task automatic run_op(input logic [31:0] v, input logic s, input logic [2:0] rm,
                          input logic es, input logic [31:0] esig, input logic [7:0] ee,
                          input logic ez, input int elat, input bit push);
        int lat;
        if (push) exp_q.push_back('{sign: es, sig: esig, expo: ee, zero: ez, rm: rm});
        int_i    = v;
        signed_i = s;
        rm_i     = rm;
        valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        int_i   = 32'hDEAD_BEEF;
        lat = 1;
        while (push && !valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        if (push) check($sformatf("latency_%08h", v), 64'(lat), 64'(elat));
    endtask

    task automatic wait_hs();
        int n = 0;
        while (valid_o && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("valid_drop", 64'(valid_o), 64'd0);
        check("ready_back", 64'(ready_o), 64'd1);
    endtask

    initial begin
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        int_i    = 32'd0;
        signed_i = 1'b0;
        rm_i     = 3'd0;
        ready_i  = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("ready_in_reset", 64'(ready_o), 64'd1);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("reset_outputs", {valid_o, sign_o, zero_o, sig_o, exp_o, rm_o}, 64'd0);
        check("reset_ready", 64'(ready_o), 64'd1);

        // Magnitude 1: worst case, ready_o low while busy
        fork
            run_op(32'h0000_0001, 1'b0, 3'd1, 1'b0, 32'h8000_0000, 8'd127, 1'b0, 12, 1'b1);
            begin
                repeat (6) @(negedge clk_i);
                check("busy_ready", 64'(ready_o), 64'd0);
            end
        join
        wait_hs();
        run_op(32'hFFFF_FFFF, 1'b1, 3'd0, 1'b1, 32'h8000_0000, 8'd127, 1'b0, 12, 1'b1);
        wait_hs();
        run_op(32'h8000_0000, 1'b1, 3'd4, 1'b1, 32'h8000_0000, 8'd158, 1'b0, 2, 1'b1);
        wait_hs();
        run_op(32'h0000_0300, 1'b0, 3'd3, 1'b0, 32'hC000_0000, 8'd136, 1'b0, 10, 1'b1);
        wait_hs();
        run_op(32'hFFFF_FFFF, 1'b0, 3'd2, 1'b0, 32'hFFFF_FFFF, 8'd158, 1'b0, 2, 1'b1);
        wait_hs();
        run_op(32'h0000_0000, 1'b0, 3'd1, 1'b0, 32'h0000_0000, 8'd0, 1'b1, 1, 1'b1);
        wait_hs();
        run_op(32'h0000_0000, 1'b1, 3'd6, 1'b0, 32'h0000_0000, 8'd0, 1'b1, 1, 1'b1);
        wait_hs();

        // Back-pressure: result held for 5 cycles, then a second operand right after
        ready_i = 1'b0;
        run_op(32'h0000_0005, 1'b0, 3'b010, 1'b0, 32'hA000_0000, 8'd129, 1'b0, 10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("hold_%0d", i), {valid_o, ready_o, sign_o, zero_o, sig_o, exp_o, rm_o},
                  {1'b1, 1'b0, 1'b0, 1'b0, 32'hA000_0000, 8'd129, 3'b010});
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("bp_valid_fall", 64'(valid_o), 64'd0);
        check("bp_ready_rise", 64'(ready_o), 64'd1);
        check("bp_rm_kept", 64'(rm_o), 64'd2);
        run_op(32'hFFFF_FD00, 1'b1, 3'd7, 1'b1, 32'hC000_0000, 8'd136, 1'b0, 10, 1'b1);
        wait_hs();

        // Reset asserted in NORM abandons the operation
        run_op(32'h0000_0001, 1'b0, 3'd5, 1'b0, 32'd0, 8'd0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rst_mid_ready", 64'(ready_o), 64'd1);
        check("rst_mid_valid", 64'(valid_o), 64'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk_i);
                #1;
                if (valid_o) seen++;
            end
            check("rst_no_valid", 64'(seen), 64'd0);
        end
        run_op(32'h0000_0300, 1'b0, 3'd0, 1'b0, 32'hC000_0000, 8'd136, 1'b0, 10, 1'b1);
        wait_hs();

        repeat (2) @(posedge clk_i);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
